// File: rtl/wb_pkg.sv
// wb_pkg: shared types and defaults for the register file write-back path
package wb_pkg;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 64;
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;
    typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_FIFO, WB_SRC_LSU} wb_src_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO buffering load results that lost write-port arbitration
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    assign dout  = mem[rp];
    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/load results onto the register file write port and tracks pending loads
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [ADDR_WIDTH-1:0]     issue_rd,
    input  logic                      alu_valid,
    input  logic [ADDR_WIDTH-1:0]     alu_rd,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [ADDR_WIDTH-1:0]     lsu_rd,
    input  logic [DATA_WIDTH-1:0]     lsu_data,
    output logic                      rf_wen,
    output logic [ADDR_WIDTH-1:0]     rf_rd,
    output logic [DATA_WIDTH-1:0]     rf_data,
    output logic [(1<<ADDR_WIDTH)-1:0] busy
);
    localparam int NR = 1 << ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;
    entry_t        head, sel;
    wb_src_t       src;
    logic          full, empty, lsu_acc;
    logic [CW-1:0] count;
    logic [NR-1:0] set_mask, clr_mask;
    // ready comes from registered count only, so execute never sees a path from alu_valid
    assign lsu_ready = count < CW'(FIFO_DEPTH);
    always_comb begin
        lsu_acc  = lsu_valid && !full;
        src      = alu_valid ? WB_SRC_ALU : !empty ? WB_SRC_FIFO : lsu_acc ? WB_SRC_LSU : WB_SRC_NONE;
        sel      = src == WB_SRC_ALU  ? entry_t'({alu_rd, alu_data}) :
                   src == WB_SRC_FIFO ? head :
                   src == WB_SRC_LSU  ? entry_t'({lsu_rd, lsu_data}) : '0;
        set_mask = issue_valid ? NR'(1) << issue_rd : '0;
        clr_mask = (src == WB_SRC_FIFO || src == WB_SRC_LSU) ? NR'(1) << sel.rd : '0;
    end
    wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_acc && src != WB_SRC_LSU),
        .din   (entry_t'({lsu_rd, lsu_data})),
        .pop   (src == WB_SRC_FIFO),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen  <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
            busy    <= '0;
        end else begin
            rf_wen  <= src != WB_SRC_NONE && sel.rd != '0;
            rf_rd   <= sel.rd;
            rf_data <= sel.data;
            // set after clear so a re-issue in the commit cycle keeps the bit
            busy    <= ((busy & ~clr_mask) | set_mask) & ~NR'(1);
        end
    end
endmodule
